// File: rtl/onehot_sel_sequencer.sv
// onehot_sel_sequencer: registered N-to-M one-hot select decoder.
// It has a direct-address mode with a valid/ready handshake and a dwell-timed auto-scan mode.
//
// Parameters
//   SEL_W    select address width
//   NUM_OUT  number of one-hot outputs (2 .. 2**SEL_W)
//   DWELL_W  width of the scan dwell count
//
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   en        block enable
//   mode      0 = direct, 1 = scan
//   in_valid  address valid (direct mode)
//   in_ready  address accept (registered)
//   in_sel    requested output index
//   dwell     scan hold length minus one
//   out       registered one-hot or all-zero select
//   cur_sel   index currently driven (0 when out is all-zero)
//   wrap      one-cycle pulse when the scan returns to index 0
//   err       one-cycle pulse when an out-of-range address is accepted

module onehot_sel_sequencer #(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 8,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic [NUM_OUT-1:0] out,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               wrap,
    output logic               err
);

    localparam logic [SEL_W:0]   NUM_LIM  = (SEL_W+1)'(NUM_OUT);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_OUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // state: mode captured from en/mode at the previous edge.
    // phase: state as seen one edge later, i.e. what the outputs
    // currently reflect. A SCAN state with a non-SCAN phase is a
    // scan entry.
    state_t state;
    state_t phase;

    logic [SEL_W-1:0]   lat_sel;
    logic [SEL_W-1:0]   scan_idx;
    logic [DWELL_W-1:0] cnt;

    logic               xfer;
    logic               in_range;
    logic               take;
    logic [SEL_W-1:0]   direct_idx;
    logic [SEL_W-1:0]   step_idx;
    logic               at_last;

    function automatic logic [NUM_OUT-1:0] onehot(
        input logic [SEL_W-1:0] idx
    );
        logic [NUM_OUT-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            v[k] = (idx == SEL_W'(k));
        end
        return v;
    endfunction

    assign xfer     = in_valid & in_ready;
    assign in_range = ({1'b0, in_sel} < NUM_LIM);
    assign take     = xfer & in_range;

    // A good transfer shows up on the very next cycle, so the
    // direct output bypasses the latch on the accepting edge.
    assign direct_idx = take ? in_sel : lat_sel;

    assign at_last  = (scan_idx == LAST_IDX);
    assign step_idx = at_last ? '0 : scan_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            phase    <= IDLE;
            in_ready <= 1'b0;
            out      <= '0;
            cur_sel  <= '0;
            wrap     <= 1'b0;
            err      <= 1'b0;
            lat_sel  <= '0;
            scan_idx <= '0;
            cnt      <= '0;
        end else begin
            if (!en) begin
                state <= IDLE;
            end else if (mode) begin
                state <= SCAN;
            end else begin
                state <= DIRECT;
            end

            phase    <= state;
            in_ready <= (state == DIRECT);
            wrap     <= 1'b0;

            // The handshake is honoured whenever in_ready was shown,
            // even if the mode is already leaving DIRECT.
            err <= xfer & ~in_range;
            if (take) begin
                lat_sel <= in_sel;
            end

            unique case (state)
                IDLE: begin
                    out      <= '0;
                    cur_sel  <= '0;
                    scan_idx <= '0;
                    cnt      <= '0;
                end

                DIRECT: begin
                    out      <= onehot(direct_idx);
                    cur_sel  <= direct_idx;
                    scan_idx <= '0;
                    cnt      <= '0;
                end

                SCAN: begin
                    if (phase != SCAN) begin
                        // Entry: start at index 0, no wrap pulse.
                        scan_idx <= '0;
                        cnt      <= dwell;
                        out      <= onehot('0);
                        cur_sel  <= '0;
                    end else if (cnt == '0) begin
                        // Step: dwell is only sampled here.
                        scan_idx <= step_idx;
                        cnt      <= dwell;
                        out      <= onehot(step_idx);
                        cur_sel  <= step_idx;
                        wrap     <= at_last;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    out      <= '0;
                    cur_sel  <= '0;
                    scan_idx <= '0;
                    cnt      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_sel_sequencer.sv
// tb_onehot_sel_sequencer: directed table, hand sequences and
// randomized traffic checked against a cycle-level reference model.

module tb_onehot_sel_sequencer;

    localparam int SEL_W   = 3;
    localparam int NUM_OUT = 6;
    localparam int DWELL_W = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic               mode;
    logic               in_valid;
    logic               in_ready;
    logic [SEL_W-1:0]   in_sel;
    logic [DWELL_W-1:0] dwell;
    logic [NUM_OUT-1:0] out;
    logic [SEL_W-1:0]   cur_sel;
    logic               wrap;
    logic               err;

    int n_pass  = 0;
    int n_total = 0;

    onehot_sel_sequencer #(
        .SEL_W   (SEL_W),
        .NUM_OUT (NUM_OUT),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .dwell    (dwell),
        .out      (out),
        .cur_sel  (cur_sel),
        .wrap     (wrap),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Reference model. Commands: 0 off, 1 direct, 2 scan. The
    // outputs after an edge follow the command sampled one edge
    // earlier. m_remain counts the cycles the scan index still has
    // to be shown, including the current one.
    int               m_cmd    = 0;
    int               m_last   = 0;
    int               m_lat    = 0;
    int               m_idx    = 0;
    int               m_remain = 0;
    logic [NUM_OUT-1:0] e_out  = '0;
    logic [SEL_W-1:0]   e_cur  = '0;
    logic               e_rdy  = 1'b0;
    logic               e_wrap = 1'b0;
    logic               e_err  = 1'b0;

    function automatic void model_step();
        bit x;
        int ph;
        if (!rst_n) begin
            m_cmd = 0; m_last = 0; m_lat = 0;
            m_idx = 0; m_remain = 0;
            e_out = '0; e_cur = '0; e_rdy = 1'b0;
            e_wrap = 1'b0; e_err = 1'b0;
            return;
        end
        x = in_valid && e_rdy;
        e_err = x && (int'(in_sel) >= NUM_OUT);
        if (x && int'(in_sel) < NUM_OUT) m_lat = int'(in_sel);
        ph = m_cmd;
        e_rdy  = (ph == 1);
        e_wrap = 1'b0;
        if (ph == 0) begin
            e_out = '0;
            e_cur = '0;
        end else if (ph == 1) begin
            e_cur = 3'(m_lat);
            e_out = 6'(1) << m_lat;
        end else begin
            if (m_last != 2) begin
                m_idx = 0;
                m_remain = int'(dwell) + 1;
            end else begin
                m_remain--;
                if (m_remain == 0) begin
                    m_idx = (m_idx + 1) % NUM_OUT;
                    e_wrap = (m_idx == 0);
                    m_remain = int'(dwell) + 1;
                end
            end
            e_cur = 3'(m_idx);
            e_out = 6'(1) << m_idx;
        end
        m_last = ph;
        m_cmd  = !en ? 0 : (mode ? 2 : 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(
        input string              nm,
        input logic [NUM_OUT-1:0] eo,
        input logic [SEL_W-1:0]   ec,
        input logic               er,
        input logic               ew,
        input logic               ee
    );
        n_total++;
        if (out === eo && cur_sel === ec && in_ready === er &&
            wrap === ew && err === ee) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got out=%b cur=%0d rdy=%b wrap=%b err=%b, want out=%b cur=%0d rdy=%b wrap=%b err=%b",
                     nm, out, cur_sel, in_ready, wrap, err,
                     eo, ec, er, ew, ee);
        end
    endtask

    task automatic chk_model(input string nm);
        chk(nm, e_out, e_cur, e_rdy, e_wrap, e_err);
    endtask

    typedef struct {
        logic               rst_n;
        logic               en;
        logic               mode;
        logic               v;
        logic [SEL_W-1:0]   sel;
        logic [NUM_OUT-1:0] eo;
        logic [SEL_W-1:0]   ec;
        logic               er;
        logic               ee;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int j;
        bit found;
        logic [SEL_W-1:0] dseq [7];

        rst_n = 1'b0; en = 1'b0; mode = 1'b0;
        in_valid = 1'b0; in_sel = '0; dwell = '0;

        // reset, direct sweep, out-of-range, en drop with transfer
        tbl.push_back('{0,0,0,0,3'd0, 6'b000000,3'd0,0,0});
        tbl.push_back('{1,1,0,0,3'd0, 6'b000000,3'd0,0,0});
        tbl.push_back('{1,1,0,0,3'd0, 6'b000001,3'd0,1,0});
        tbl.push_back('{1,1,0,1,3'd0, 6'b000001,3'd0,1,0});
        tbl.push_back('{1,1,0,1,3'd1, 6'b000010,3'd1,1,0});
        tbl.push_back('{1,1,0,1,3'd2, 6'b000100,3'd2,1,0});
        tbl.push_back('{1,1,0,1,3'd3, 6'b001000,3'd3,1,0});
        tbl.push_back('{1,1,0,1,3'd4, 6'b010000,3'd4,1,0});
        tbl.push_back('{1,1,0,1,3'd5, 6'b100000,3'd5,1,0});
        tbl.push_back('{1,1,0,1,3'd3, 6'b001000,3'd3,1,0});
        tbl.push_back('{1,1,0,1,3'd6, 6'b001000,3'd3,1,1});
        tbl.push_back('{1,1,0,0,3'd0, 6'b001000,3'd3,1,0});
        tbl.push_back('{1,1,0,1,3'd7, 6'b001000,3'd3,1,1});
        tbl.push_back('{1,1,0,0,3'd0, 6'b001000,3'd3,1,0});
        tbl.push_back('{1,0,0,1,3'd2, 6'b000100,3'd2,1,0});
        tbl.push_back('{1,0,0,0,3'd0, 6'b000000,3'd0,0,0});
        tbl.push_back('{1,1,0,0,3'd0, 6'b000000,3'd0,0,0});
        tbl.push_back('{1,1,0,0,3'd0, 6'b000100,3'd2,1,0});

        #1;
        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n; en = tbl[i].en;
            mode = tbl[i].mode; in_valid = tbl[i].v;
            in_sel = tbl[i].sel;
            tick();
            chk($sformatf("vec%0d", i), tbl[i].eo, tbl[i].ec,
                tbl[i].er, 1'b0, tbl[i].ee);
        end
        in_valid = 1'b0;

        // scan, dwell=2: each index held 3 cycles, period 18
        mode = 1'b1; dwell = 4'd2;
        tick();
        chk("scan_switch", 6'b000100, 3'd2, 1'b1, 1'b0, 1'b0);
        for (j = 0; j <= 18; j++) begin
            tick();
            idx = (j / 3) % NUM_OUT;
            chk($sformatf("scan_j%0d", j), 6'(1) << idx, 3'(idx),
                1'b0, (j == 18), 1'b0);
        end

        // dwell drops to 0 mid-dwell of the second index 0
        tick();
        chk("dwell_old", 6'b000001, 3'd0, 1'b0, 1'b0, 1'b0);
        dwell = 4'd0;
        dseq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        for (int k = 0; k < 7; k++) begin
            tick();
            chk($sformatf("dwell0_%0d", k), 6'(1) << dseq[k], dseq[k],
                1'b0, (k == 6), 1'b0);
        end

        // enable / mode interaction
        mode = 1'b0;
        tick();
        tick();
        chk("back_direct", 6'b000100, 3'd2, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1; in_sel = 3'd4;
        tick();
        chk("latch4", 6'b010000, 3'd4, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0; mode = 1'b1;
        tick();
        tick();
        chk("scan_entry", 6'b000001, 3'd0, 1'b0, 1'b0, 1'b0);
        en = 1'b0;
        tick();
        tick();
        chk("idle_a", 6'b000000, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("idle_b", 6'b000000, 3'd0, 1'b0, 1'b0, 1'b0);
        en = 1'b1; mode = 1'b0;
        tick();
        chk("reen_first", 6'b000000, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("reen_direct", 6'b010000, 3'd4, 1'b1, 1'b0, 1'b0);

        // reset during scan index 3
        mode = 1'b1; dwell = 4'd2;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (cur_sel == 3'd3) found = 1'b1;
        end
        n_total++;
        if (found) n_pass++;
        else $display("FAIL scan_reach3: got cur=%0d, want 3", cur_sel);
        rst_n = 1'b0;
        tick();
        chk("mid_reset", 6'b000000, 3'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1; mode = 1'b0;
        tick();
        tick();
        chk("post_reset", 6'b000001, 3'd0, 1'b1, 1'b0, 1'b0);

        // randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            en       = ($urandom_range(0, 11) != 0);
            if ($urandom_range(0, 14) == 0) mode = ~mode;
            in_valid = $urandom_range(0, 1);
            in_sel   = 3'($urandom_range(0, 7));
            dwell    = 4'($urandom_range(0, 3));
            tick();
            chk($sformatf("rand%0d", k), e_out, e_cur, e_rdy,
                e_wrap, e_err);
        end
        chk_model("final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
